// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states
// and the access-size decode used by both the top level and the lane aligner.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } stateT;

    // The low two bits of funct3 carry the access size for every legal code.
    function automatic logic [3:0] sizeBytes(input logic [2:0] fun3);
        logic [3:0] n;
        case (fun3[1:0])
            2'b00:   n = 4'd1;
            2'b01:   n = 4'd2;
            2'b10:   n = 4'd4;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for RV64 sized accesses: byte enables, store
// data shift, load extraction with sign/zero extension and misalignment flag.
module lsu_align
    import dmem_pkg::*;
(
    input  logic [2:0]  fun3,
    input  logic [2:0]  lane,
    input  logic [63:0] wdata,
    input  logic [63:0] rowData,
    output logic [7:0]  byteEn,
    output logic [63:0] wdataLane,
    output logic [63:0] loadData,
    output logic        misaligned
);

    logic [5:0]  shamt;
    logic [3:0]  sz;
    logic [7:0]  sizeMask;
    logic [63:0] rowShift;

    always_comb begin
        shamt    = {lane, 3'b000};
        sz       = sizeBytes(fun3);
        sizeMask = 8'h00;
        case (fun3[1:0])
            2'b00:   sizeMask = 8'h01;
            2'b01:   sizeMask = 8'h03;
            2'b10:   sizeMask = 8'h0F;
            default: sizeMask = 8'hFF;
        endcase

        byteEn    = sizeMask << lane;
        wdataLane = wdata << shamt;
        rowShift  = rowData >> shamt;
        // A size of 8 wraps sz[2:0] to 0, so the mask becomes 3'b111 as required.
        misaligned = (lane & (sz[2:0] - 3'd1)) != 3'd0;

        loadData = '0;
        case (fun3)
            F3_B:    loadData = {{56{rowShift[7]}},  rowShift[7:0]};
            F3_H:    loadData = {{48{rowShift[15]}}, rowShift[15:0]};
            F3_W:    loadData = {{32{rowShift[31]}}, rowShift[31:0]};
            F3_D:    loadData = rowShift;
            F3_BU:   loadData = {56'b0, rowShift[7:0]};
            F3_HU:   loadData = {48'b0, rowShift[15:0]};
            F3_WU:   loadData = {32'b0, rowShift[31:0]};
            default: loadData = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: one request at a time, fixed latency,
// byte-enabled doubleword array plus a single memory-mapped LED register.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int               Nbits       = 64,
    parameter int               DEPTH_WORDS = 256,
    parameter int               LATENCY     = 2,
    parameter logic [Nbits-1:0] LED_ADDR    = 64'h1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [Nbits-1:0] req_addr,
    input  logic [Nbits-1:0] req_wdata,
    input  logic [2:0]       req_fun3,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [Nbits-1:0] resp_rdata,
    output logic             resp_err,
    output logic             led
);

    localparam int               AW          = $clog2(DEPTH_WORDS);
    localparam int               CW          = $clog2(LATENCY + 1);
    localparam logic [Nbits-1:0] ARRAY_BYTES = Nbits'(DEPTH_WORDS * 8);

    stateT            stateReg;
    logic [CW-1:0]    cntReg;
    logic             writeReg;
    logic [Nbits-1:0] addrReg;
    logic [Nbits-1:0] wdataReg;
    logic [2:0]       fun3Reg;
    logic             ledReg;

    logic [63:0] mem [DEPTH_WORDS];

    logic             accept;
    logic             commit;
    logic             opWrite;
    logic [Nbits-1:0] opAddr;
    logic [Nbits-1:0] opWdata;
    logic [2:0]       opFun3;
    logic [AW-1:0]    opIdx;
    logic             isLed;
    logic             inArray;
    logic             illegalFun3;
    logic             opErr;
    logic             memWe;
    logic [63:0]      rowData;
    logic [7:0]       byteEn;
    logic [63:0]      wdataLane;
    logic [63:0]      loadData;
    logic             misaligned;

    // With LATENCY==1 the commit edge is the accept edge, so the live request
    // is used directly; otherwise the captured copy is.
    always_comb begin
        accept  = (stateReg == IDLE) && req_valid && req_ready;
        commit  = (accept && (LATENCY == 1)) ||
                  ((stateReg == WAIT) && (cntReg <= CW'(1)));
        opWrite = (stateReg == IDLE) ? req_write : writeReg;
        opAddr  = (stateReg == IDLE) ? req_addr  : addrReg;
        opWdata = (stateReg == IDLE) ? req_wdata : wdataReg;
        opFun3  = (stateReg == IDLE) ? req_fun3  : fun3Reg;

        opIdx       = opAddr[AW+2:3];
        isLed       = (opAddr == LED_ADDR);
        inArray     = (opAddr < ARRAY_BYTES);
        illegalFun3 = (opFun3 == 3'b111) || (opWrite && opFun3[2]);
        opErr       = illegalFun3 || misaligned || !(inArray || isLed);
        memWe       = commit && opWrite && !opErr && inArray && !rst;

        // Placing the LED bit in its lane lets the aligner extract it unchanged.
        rowData = isLed ? (64'(ledReg) << {opAddr[2:0], 3'b000}) : mem[opIdx];
    end

    lsu_align uAlign (
        .fun3       (opFun3),
        .lane       (opAddr[2:0]),
        .wdata      (opWdata),
        .rowData    (rowData),
        .byteEn     (byteEn),
        .wdataLane  (wdataLane),
        .loadData   (loadData),
        .misaligned (misaligned)
    );

    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int b = 0; b < 8; b++) begin
                if (byteEn[b]) begin
                    mem[opIdx][b*8 +: 8] <= wdataLane[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg   <= IDLE;
            cntReg     <= '0;
            writeReg   <= 1'b0;
            addrReg    <= '0;
            wdataReg   <= '0;
            fun3Reg    <= '0;
            ledReg     <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (accept) begin
                        writeReg  <= req_write;
                        addrReg   <= req_addr;
                        wdataReg  <= req_wdata;
                        fun3Reg   <= req_fun3;
                        cntReg    <= CW'(LATENCY - 1);
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            stateReg   <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            stateReg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cntReg <= cntReg - CW'(1);
                    if (cntReg <= CW'(1)) begin
                        stateReg   <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        stateReg   <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: stateReg <= IDLE;
            endcase

            if (commit) begin
                resp_rdata <= (opWrite || opErr) ? '0 : loadData;
                resp_err   <= opErr;
                if (opWrite && !opErr && isLed) begin
                    ledReg <= opWdata[0];
                end
            end
        end
    end

    assign led = ledReg;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the CPU's MEM-stage load/store port. It accepts one request at a time over a valid/ready handshake, models a fixed access latency, and performs RV64 sized loads and stores (byte, half, word, double, with sign/zero extension). It returns the result over a response valid/ready handshake. It also decodes one memory-mapped LED register, which drives the board LED.

Parameters:
Nbits, 64, data and address width
DEPTH_WORDS, 256, number of 64-bit doublewords in the array (byte range 0 .. DEPTH_WORDS*8-1)
LATENCY, 2, cycles from request accept to response valid; legal range >= 1
LED_ADDR, 64'h1000, byte address of the LED register; must lie outside the array range

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  Nbits  byte address
req_wdata  in  Nbits  store data, right-aligned (size taken from low bits)
req_fun3  in  3  RISC-V funct3 size/sign code
resp_valid  out  1  response present
resp_ready  in  1  CPU accepts the response
resp_rdata  out  Nbits  load result, extended to 64 bits; 0 for stores and errors
resp_err  out  1  misaligned, out-of-range or illegal fun3
led  out  1  bit 0 of the LED register

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: FSM = IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, led=0. Array contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture write, addr, wdata and fun3. Load the latency counter with LATENCY-1. If LATENCY==1 go to RESP, else go to WAIT.
  - WAIT: req_ready=0. Decrement the counter. When the counter reaches 0, go to RESP.
  - RESP: req_ready=0, resp_valid=1. rdata and err stay stable until resp_ready. On resp_valid&&resp_ready, go to IDLE.
- Timing: a request accepted at edge T produces resp_valid high from cycle T+LATENCY. There is no back-to-back pipelining; the earliest next accept is the cycle after the response handshake.
- Commit point:
  - Store array write and LED write happen on the edge that enters RESP, exactly once.
  - Load data is sampled on that same edge and registered into resp_rdata.
- fun3 decode:
  - 000 = byte, 001 = half, 010 = word, 011 = double: signed for loads.
  - 100 = bu, 101 = hu, 110 = wu: unsigned loads only.
  - 111 = illegal. Stores with fun3 >= 100 are illegal.
- Alignment: the address must be aligned to the access size (half: addr[0]=0; word: addr[1:0]=0; double: addr[2:0]=0).
- Lane selection:
  - The doubleword index is addr[$clog2(DEPTH_WORDS)+2:3]; the byte lane is addr[2:0].
  - Stores merge only the selected bytes (byte-enable write). Other bytes are unchanged.
- Errors (resp_err=1): misaligned, illegal fun3, or address outside the array and not equal to LED_ADDR. On error there is no write, resp_rdata=0, and the handshake still completes normally.
- LED register:
  - Any legal-size, aligned store to LED_ADDR sets led to wdata[0].
  - A load from LED_ADDR returns {63'b0, led}, extended per fun3.
- Reset mid-operation: rst in WAIT or RESP aborts to IDLE. A store not yet committed is dropped; resp_valid drops the cycle after rst.
- resp_ready held high in IDLE/WAIT has no effect.
- req_valid while req_ready=0 is ignored; the CPU holds it (stall).
- Counter width is $clog2(LATENCY+1).

Decomposition:
- dmem_pkg:
  - fun3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU).
  - State enum: IDLE, WAIT, RESP.
  - Size-decode function returning byte count.
- Sub-module lsu_align (combinational): byte-enable generation, store data lane shift, load extract with sign/zero extension, misalignment flag.
- Top module: FSM, latency counter, array, LED register, address-range check.

Test Plan:
- Store then load with LATENCY=2:
  - sd addr 0x10 wdata 64'h8877_6655_4433_2211, accepted at T -> resp_valid at T+2, err=0.
  - Then ld 0x10 -> rdata 64'h8877_6655_4433_2211.
- Sized loads after the above:
  - lb 0x17 -> 64'hFFFF_FFFF_FFFF_FF88; lbu 0x17 -> 64'h88.
  - lh 0x16 -> 64'hFFFF_FFFF_FFFF_8877; lwu 0x14 -> 64'h8877_6655.
- Byte-merge store: sb 0x11 wdata 0xAB, then ld 0x10 -> 64'h8877_6655_4433_AB11.
- Errors:
  - lw 0x12 -> err=1, rdata=0.
  - sd 0x800 (DEPTH 256) -> err=1; a later ld 0x800 -> err=1.
  - fun3=111 -> err=1, no write.
- LED and backpressure:
  - sw LED_ADDR wdata 1 -> led=1 after the commit edge.
  - Hold resp_ready=0 for 3 cycles -> resp_valid/rdata stable, req_ready=0 throughout.
  - lw LED_ADDR -> rdata 1.
- Reset abort: sd 0x20 accepted, rst asserted in WAIT -> IDLE next cycle, resp_valid=0, led=0; then ld 0x20 returns the prior contents unchanged.
